// File: rtl/cnt_prog_clk_div.sv
// rtl/cnt_prog_clk_div.sv - programmable clock divider with shadowed divisor/mode
//
// Purpose:
//   Divides clk by a programmable N. The divisor and the output mode are held in
//   shadow registers. These registers reload only at a period wrap or on restart,
//   so a running period is never truncated or stretched.
//
// Ports:
//   clk      in   1      single clock, rising edge
//   reset    in   1      asynchronous active-low reset
//   en       in   1      count enable; low freezes the divider (tick forced low)
//   restart  in   1      synchronous restart, reloads divisor/mode immediately
//   div      in   WIDTH  requested divisor (0 and 1 are treated as 2)
//   mode     in   1      0 = pulse output, 1 = square output
//   Y        out  1      registered divided clock
//   tick     out  1      registered one-cycle pulse in the cycle after each wrap
//   cnt      out  WIDTH  current phase count, 0 .. n_act-1

module cnt_prog_clk_div #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             restart,
    input  logic [WIDTH-1:0] div,
    input  logic             mode,
    output logic             Y,
    output logic             tick,
    output logic [WIDTH-1:0] cnt
);

    localparam logic [WIDTH-1:0] N_MIN = WIDTH'(2);

    logic [WIDTH-1:0] cnt_q,  cnt_d;
    logic [WIDTH-1:0] n_q,    n_d;
    logic             mode_q, mode_d;
    logic             tick_q, tick_d;
    logic             y_q,    y_d;

    logic [WIDTH-1:0] n_load;
    logic             wrap;

    // Divisors below 2 cannot produce a meaningful period.
    assign n_load = (div < N_MIN) ? N_MIN : div;
    assign wrap   = (cnt_q == n_q - WIDTH'(1));

    always_comb begin
        cnt_d  = cnt_q;
        n_d    = n_q;
        mode_d = mode_q;
        tick_d = 1'b0;
        y_d    = y_q;

        if (restart) begin
            cnt_d  = '0;
            n_d    = n_load;
            mode_d = mode;
            y_d    = 1'b0;
        end else if (en) begin
            if (wrap) begin
                cnt_d  = '0;
                n_d    = n_load;
                mode_d = mode;
                tick_d = 1'b1;
            end else begin
                cnt_d  = cnt_q + WIDTH'(1);
            end
            // Y is computed from next-state values, so the first cycle of a
            // new period already reflects the newly adopted divisor and mode.
            if (mode_d) begin
                y_d = (cnt_d >= (n_d >> 1));
            end else begin
                y_d = tick_d;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            n_q    <= N_MIN;
            mode_q <= 1'b0;
            tick_q <= 1'b0;
            y_q    <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            n_q    <= n_d;
            mode_q <= mode_d;
            tick_q <= tick_d;
            y_q    <= y_d;
        end
    end

    assign cnt  = cnt_q;
    assign tick = tick_q;
    assign Y    = y_q;

endmodule

// File: tb/tb_cnt_prog_clk_div.sv
// tb/tb_cnt_prog_clk_div.sv - directed self-checking bench for cnt_prog_clk_div

module tb_cnt_prog_clk_div;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic             restart;
    logic [WIDTH-1:0] div;
    logic             mode;
    logic             Y;
    logic             tick;
    logic [WIDTH-1:0] cnt;

    int n_vec  = 0;
    int n_miss = 0;
    int step   = 0;

    cnt_prog_clk_div #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .restart (restart),
        .div     (div),
        .mode    (mode),
        .Y       (Y),
        .tick    (tick),
        .cnt     (cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Apply inputs, take one rising edge, then check outputs 2 ns after it.
    task automatic cyc(input logic e, input logic rs, input int d, input logic m,
                       input int ec, input int ey, input int et);
        en      = e;
        restart = rs;
        div     = WIDTH'(d);
        mode    = m;
        @(posedge clk);
        #2;
        step++;
        chk($sformatf("s%0d cnt", step),  32'(cnt),  32'(ec));
        chk($sformatf("s%0d Y", step),    32'(Y),    32'(ey));
        chk($sformatf("s%0d tick", step), 32'(tick), 32'(et));
    endtask

    initial begin
        reset   = 1'b0;
        en      = 1'b1;
        restart = 1'b0;
        div     = WIDTH'(4);
        mode    = 1'b1;

        // Reset held across clock edges
        repeat (2) @(posedge clk);
        #2;
        chk("rst cnt",  32'(cnt),  0);
        chk("rst Y",    32'(Y),    0);
        chk("rst tick", 32'(tick), 0);
        #3 reset = 1'b1;
        #1;

        // First period after reset: 2 cycles, pulse mode; div/mode adopted at wrap
        cyc(1, 0, 4, 1, 1, 0, 0);
        cyc(1, 0, 4, 1, 0, 0, 1);

        // Restart with div=4 square: cnt 0,1,2,3 / Y 0,0,1,1
        cyc(1, 1, 4, 1, 0, 0, 0);
        cyc(1, 0, 4, 1, 1, 0, 0);
        cyc(1, 0, 4, 1, 2, 1, 0);
        cyc(1, 0, 4, 1, 3, 1, 0);
        cyc(1, 0, 4, 1, 0, 0, 1);
        cyc(1, 0, 4, 1, 1, 0, 0);
        cyc(1, 0, 4, 1, 2, 1, 0);
        cyc(1, 0, 4, 1, 3, 1, 0);
        cyc(1, 0, 4, 1, 0, 0, 1);

        // Change to div=6 pulse at cnt==1: current square period completes
        cyc(1, 0, 4, 1, 1, 0, 0);
        cyc(1, 0, 6, 0, 2, 1, 0);
        cyc(1, 0, 6, 0, 3, 1, 0);
        cyc(1, 0, 6, 0, 0, 1, 1);
        cyc(1, 0, 6, 0, 1, 0, 0);
        cyc(1, 0, 6, 0, 2, 0, 0);
        cyc(1, 0, 6, 0, 3, 0, 0);
        cyc(1, 0, 6, 0, 4, 0, 0);
        cyc(1, 0, 6, 0, 5, 0, 0);
        cyc(1, 0, 6, 0, 0, 1, 1);
        cyc(1, 0, 6, 0, 1, 0, 0);

        // Enable low at cnt==2 for 3 cycles, then resume
        cyc(1, 1, 4, 1, 0, 0, 0);
        cyc(1, 0, 4, 1, 1, 0, 0);
        cyc(1, 0, 4, 1, 2, 1, 0);
        cyc(0, 0, 4, 1, 2, 1, 0);
        cyc(0, 0, 4, 1, 2, 1, 0);
        cyc(0, 0, 4, 1, 2, 1, 0);
        cyc(1, 0, 4, 1, 3, 1, 0);
        cyc(1, 0, 4, 1, 0, 0, 1);
        cyc(1, 0, 4, 1, 1, 0, 0);
        cyc(1, 0, 4, 1, 2, 1, 0);
        // Restart wins over en=0 and loads div=5 square
        cyc(0, 1, 5, 1, 0, 0, 0);
        cyc(1, 0, 5, 1, 1, 0, 0);
        cyc(1, 0, 5, 1, 2, 1, 0);
        cyc(1, 0, 5, 1, 3, 1, 0);
        cyc(1, 0, 5, 1, 4, 1, 0);
        cyc(1, 0, 5, 1, 0, 0, 1);
        cyc(1, 0, 5, 1, 1, 0, 0);

        // div=0 and div=1 both behave as 2
        cyc(1, 1, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 1, 1, 1, 0);
        cyc(1, 0, 0, 1, 0, 0, 1);
        cyc(1, 0, 0, 1, 1, 1, 0);
        cyc(1, 0, 0, 1, 0, 0, 1);
        cyc(1, 1, 1, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 1, 0, 0);
        cyc(1, 0, 1, 0, 0, 1, 1);
        cyc(1, 0, 1, 0, 1, 0, 0);
        cyc(1, 0, 1, 0, 0, 1, 1);

        // Maximum period 255 square: low 127, high 128, no overflow
        begin
            int hi_cnt;
            int lo_cnt;
            hi_cnt = 0;
            lo_cnt = 0;
            cyc(1, 1, 255, 1, 0, 0, 0);
            lo_cnt++;
            for (int k = 1; k < 2 * 255 + 1; k++) begin
                cyc(1, 0, 255, 1, k % 255, ((k % 255) >= 127) ? 1 : 0, ((k % 255) == 0) ? 1 : 0);
                if (k < 255) begin
                    if (Y) hi_cnt++;
                    else   lo_cnt++;
                end
            end
            chk("max low cycles",  32'(lo_cnt), 127);
            chk("max high cycles", 32'(hi_cnt), 128);
        end

        // Asynchronous reset at cnt==3 between edges
        cyc(1, 1, 4, 1, 0, 0, 0);
        cyc(1, 0, 4, 1, 1, 0, 0);
        cyc(1, 0, 4, 1, 2, 1, 0);
        cyc(1, 0, 4, 1, 3, 1, 0);
        #1 reset = 1'b0;
        #1;
        chk("async cnt",  32'(cnt),  0);
        chk("async Y",    32'(Y),    0);
        chk("async tick", 32'(tick), 0);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        // First period after release: 2 cycles in pulse mode, then div=6 pulse
        cyc(1, 0, 6, 0, 1, 0, 0);
        cyc(1, 0, 6, 0, 0, 1, 1);
        cyc(1, 0, 6, 0, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
